imem_loader: RTL and testbench

Boot-time writer for the instruction memory: accepts a big-endian byte stream over a valid/ready handshake and assembles it into 32-bit words. It writes the words into the writable instruction-memory port at consecutive word-aligned byte addresses. While loading, it holds the CPU; it releases the CPU once the advertised number of words has been written. It sits between the host/UART byte source and the instruction memory write port, ahead of the fetch stage.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic [15:0] o_words_loaded,
  output logic        o_cpu_hold,
  output logic        o_done,
  output logic        o_error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [31:0] LP_DEPTH = 32'(DEPTH);

  logic [2:0]  r_state;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_hdr_hi;
  logic [15:0] r_count;
  logic [23:0] r_word;
  logic        r_mem_write;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;
  logic [15:0] r_words;
  logic        r_error;

  logic        w_accept;
  logic [15:0] w_count_full;
  logic        w_too_big;
  logic [15:0] w_words_next;
  logic [31:0] w_addr;

  // Ready is a pure state decode, so at most one byte is taken per cycle.
  assign o_byte_ready = (r_state == S_HDR) || (r_state == S_LOAD);
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_count_full = {r_hdr_hi, i_byte_in};
  assign w_too_big    = {16'd0, w_count_full} > LP_DEPTH;
  assign w_words_next = r_words + 16'd1;
  assign w_addr       = BASE_ADDR + {14'd0, r_words, 2'b00};

  assign o_mem_write      = r_mem_write;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;
  assign o_words_loaded   = r_words;
  assign o_cpu_hold       = (r_state != S_DONE);
  assign o_done           = (r_state == S_DONE);
  assign o_error          = r_error;

  // Main sequencer: header capture, big-endian word assembly and write issue.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_byte_idx       <= 2'd0;
      r_hdr_hi         <= 8'd0;
      r_count          <= 16'd0;
      r_word           <= 24'd0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= BASE_ADDR;
      r_mem_write_data <= 32'd0;
      r_words          <= 16'd0;
      r_error          <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_HDR;
            r_words    <= 16'd0;
            r_byte_idx <= 2'd0;
            r_error    <= 1'b0;
            r_hdr_hi   <= 8'd0;
            r_count    <= 16'd0;
            r_word     <= 24'd0;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            if (r_byte_idx == 2'd0) begin
              r_hdr_hi   <= i_byte_in;
              r_byte_idx <= 2'd1;
            end else begin
              r_count    <= w_count_full;
              r_byte_idx <= 2'd0;
              if (w_count_full == 16'd0) begin
                r_state <= S_DONE;
              end else if (w_too_big) begin
                r_state <= S_ERR;
                r_error <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_mem_write      <= 1'b1;
              r_mem_write_data <= {r_word, i_byte_in};
              r_mem_address    <= w_addr;
              r_words          <= w_words_next;
              if (w_words_next == r_count) begin
                r_state <= S_DONE;
              end
            end else begin
              r_word <= {r_word[15:0], i_byte_in};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader
module tb_imem_loader;

  localparam int          DEPTH     = 1024;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_byte_in = 8'd0;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready;
  logic        o_mem_write;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [15:0] o_words_loaded;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_byte_in        (i_byte_in),
    .i_byte_valid     (i_byte_valid),
    .o_byte_ready     (o_byte_ready),
    .o_mem_write      (o_mem_write),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .o_words_loaded   (o_words_loaded),
    .o_cpu_hold       (o_cpu_hold),
    .o_done           (o_done),
    .o_error          (o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
    bit          last;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] payload[$];
  int          gap_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sent = 0;
  int          accepted = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: counts accepted bytes and checks every write against the scoreboard.
  initial begin
    int last_wr = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_byte_valid && o_byte_ready) accepted++;
      if (o_mem_write === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", o_mem_address, e.addr);
          chk("wr_data", o_mem_write_data, e.data);
          chk("wr_words", {16'd0, o_words_loaded}, e.idx + 1);
          chk("wr_done", {31'd0, o_done}, {31'd0, e.last});
          chk("wr_hold", {31'd0, o_cpu_hold}, {31'd0, !e.last});
          if (e.gap != 0) chk("wr_spacing", cyc - last_wr, e.gap);
        end
        last_wr = cyc;
      end
    end
  end

  function automatic int next_gap(input int maxgap);
    if (gap_q.size() != 0) return gap_q.pop_front();
    return int'($urandom_range(0, maxgap));
  endfunction

  task automatic do_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    i_byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    i_byte_in = b;
    i_byte_valid = 1'b1;
    t = 0;
    while (!o_byte_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ready_wait", {31'd0, o_byte_ready}, 32'd1);
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
    sent++;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin @(posedge clk); #1; t++; end
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  // Full load of the words in payload; expected writes derive from address = base + 4*k.
  task automatic load(input int maxgap);
    int n;
    logic [15:0] cnt;
    logic [31:0] w;
    exp_t e;
    n = payload.size();
    cnt = n[15:0];
    do_start();
    chk("ready_after_start", {31'd0, o_byte_ready}, 32'd1);
    chk("hold_after_start", {31'd0, o_cpu_hold}, 32'd1);
    chk("words_clear", {16'd0, o_words_loaded}, 32'd0);
    send_byte(cnt[15:8], next_gap(maxgap));
    send_byte(cnt[7:0], next_gap(maxgap));
    for (int k = 0; k < n; k++) begin
      w = payload[k];
      e.addr = BASE_ADDR + 32'(4 * k);
      e.data = w;
      e.idx  = k;
      e.last = (k == n - 1);
      e.gap  = (maxgap == 0 && k > 0) ? 4 : 0;
      sb.push_back(e);
      send_byte(w[31:24], next_gap(maxgap));
      send_byte(w[23:16], next_gap(maxgap));
      send_byte(w[15:8],  next_gap(maxgap));
      send_byte(w[7:0],   next_gap(maxgap));
    end
    chk("done_after_load", {31'd0, o_done}, 32'd1);
    drain();
    chk("pulse_one_cycle", {31'd0, o_mem_write}, 32'd0);
    chk("done_final", {31'd0, o_done}, 32'd1);
    chk("hold_final", {31'd0, o_cpu_hold}, 32'd0);
    chk("words_final", {16'd0, o_words_loaded}, n);
    chk("bytes_accepted", accepted, sent);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd0);
    chk({tag, "_wr"},    {31'd0, o_mem_write}, 32'd0);
    chk({tag, "_addr"},  o_mem_address, BASE_ADDR);
    chk({tag, "_data"},  o_mem_write_data, 32'd0);
    chk({tag, "_words"}, {16'd0, o_words_loaded}, 32'd0);
    chk({tag, "_hold"},  {31'd0, o_cpu_hold}, 32'd1);
    chk({tag, "_done"},  {31'd0, o_done}, 32'd0);
    chk({tag, "_err"},   {31'd0, o_error}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    i_reset = 1'b0;
    @(posedge clk); #1;

    // Nominal three-word load with the stream held valid.
    payload = '{32'h12345678, 32'h9ABCDEF0, 32'h0000002A};
    load(0);

    // Zero count goes straight to DONE.
    payload.delete();
    load(0);

    // Overflow header, then recovery through a new Start.
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk("ovf_err", {31'd0, o_error}, 32'd1);
    chk("ovf_ready", {31'd0, o_byte_ready}, 32'd0);
    chk("ovf_hold", {31'd0, o_cpu_hold}, 32'd1);
    chk("ovf_done", {31'd0, o_done}, 32'd0);
    i_byte_in = 8'h55;
    i_byte_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    i_byte_valid = 1'b0;
    chk("ovf_no_accept", accepted, sent);
    do_start();
    chk("ovf_clear", {31'd0, o_error}, 32'd0);
    chk("ovf_rehdr", {31'd0, o_byte_ready}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("ovf_recover_done", {31'd0, o_done}, 32'd1);

    // Stalled stream: valid pattern 1,0,0,1,0,1,1 across the word bytes.
    payload = '{32'hCAFEF00D};
    gap_q = '{0, 0, 0, 2, 1, 0};
    load(0);

    // Reload from DONE with two words.
    payload = '{32'hDEADBEEF, 32'h01020304};
    load(0);

    // Randomized loads with random stalls.
    for (int r = 0; r < 5; r++) begin
      payload.delete();
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) payload.push_back($urandom);
      load(3);
    end

    // Largest legal count fills the memory.
    payload.delete();
    for (int k = 0; k < DEPTH; k++) payload.push_back($urandom);
    load(0);

    // Reset mid-stream aborts the load with no write.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    i_reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_vals("midrst");
    i_reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_no_wr", {31'd0, o_mem_write}, 32'd0);
    chk("midrst_bytes", accepted, sent);

    // Clean load after the abort restarts from the base address.
    payload = '{32'hA5A5_5A5A};
    load(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
